// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, MSB first,
// with valid/ready handshakes on the operand and result sides.
module seq_divider #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic [1:0]    dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on valid on either side.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CW = $clog2(DW + 1);

  state_e        state_q;
  logic [DW-1:0] dvd_q;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] rem_q;
  logic [CW-1:0] cnt_q;
  logic          dz_q;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          take;
  logic [VW-1:0] rem_d;
  logic [DW-1:0] quo_d;

  // The kept remainder is always below the divisor, so VW+1 bits hold the trial.
  always_comb begin
    trial = {rem_q, dvd_q[DW-1]};
    diff  = trial - {1'b0, dvs_q};
    take  = (trial >= {1'b0, dvs_q});
    rem_d = take ? diff[VW-1:0] : trial[VW-1:0];
    quo_d = (quo_q << 1) | DW'(take);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      dvd_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= CW'(DW);
            dz_q     <= (divisor == '0);
            in_ready <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (dz_q) begin
            // Zero divisor spends a single cycle here instead of iterating.
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            dvd_q <= dvd_q << 1;
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              quotient  <= quo_d;
              remainder <= rem_d;
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (DW=4, VW=2): vector table, backpressure, reset abort,
// multiplier cross-check and full operand sweep against a reference model.
module tb_seq_divider;

  localparam int W = 7;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       div_zero;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0] a;
    logic [1:0] b;
    logic [3:0] q;
    logic [1:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[8];

  seq_divider #(.DW(4), .VW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [1:0] b,
                        input logic [3:0] eq, input logic [1:0] er, input logic edz,
                        input int hold, input int exp_lat, input bit noisy);
    int t;
    int lat;
    logic [W-1:0] e;
    string tag;
    tag = $sformatf("%0d/%0d", a, b);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check({tag, " accept timeout"}, 0, 1);
    @(posedge clk);
    exp_q.push_back({eq, er, edz});
    #1;
    in_valid = 1'b0;
    dividend = 4'($urandom);
    divisor  = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = 4'($urandom);
        divisor  = 2'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    if (lat == 40) check({tag, " result timeout"}, 0, 1);
    if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
    e = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " held out_valid"}, int'(out_valid), 1);
      check({tag, " held in_ready"}, int'(in_ready), 0);
      check({tag, " held quotient"}, int'(quotient), int'(e[6:3]));
      check({tag, " held remainder"}, int'(remainder), int'(e[2:1]));
    end
    @(negedge clk);
    out_ready = 1'b1;
    e = exp_q.pop_front();
    check({tag, " out_valid"}, int'(out_valid), 1);
    check({tag, " quotient"}, int'(quotient), int'(e[6:3]));
    check({tag, " remainder"}, int'(remainder), int'(e[2:1]));
    check({tag, " div_zero"}, int'(div_zero), int'(e[0]));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " post out_valid"}, int'(out_valid), 0);
    check({tag, " post in_ready"}, int'(in_ready), 1);
    check({tag, " kept quotient"}, int'(quotient), int'(e[6:3]));
    if (noisy) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1;
        check({tag, " no stray accept"}, int'(in_ready), 1);
        check({tag, " no stray result"}, int'(out_valid), 0);
      end
    end
  endtask

  task automatic run_model(input int a, input int b, input int hold);
    if (b == 0) run_op(4'(a), 2'(b), 4'hf, 2'd0, 1'b1, hold, 1, 1'b0);
    else run_op(4'(a), 2'(b), 4'(a / b), 2'(a % b), 1'b0, hold, 4, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{a: 4'd9,  b: 2'd2, q: 4'd4,  r: 2'd1, dz: 1'b0};
    vecs[1] = '{a: 4'd15, b: 2'd3, q: 4'd5,  r: 2'd0, dz: 1'b0};
    vecs[2] = '{a: 4'd2,  b: 2'd3, q: 4'd0,  r: 2'd2, dz: 1'b0};
    vecs[3] = '{a: 4'd7,  b: 2'd0, q: 4'd15, r: 2'd0, dz: 1'b1};
    vecs[4] = '{a: 4'd12, b: 2'd3, q: 4'd4,  r: 2'd0, dz: 1'b0};
    vecs[5] = '{a: 4'd15, b: 2'd1, q: 4'd15, r: 2'd0, dz: 1'b0};
    vecs[6] = '{a: 4'd3,  b: 2'd2, q: 4'd1,  r: 2'd1, dz: 1'b0};
    vecs[7] = '{a: 4'd11, b: 2'd3, q: 4'd3,  r: 2'd2, dz: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset div_zero", int'(div_zero), 0);
    check("reset state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 0,
             (vecs[i].b == 2'd0) ? 1 : 4, 1'b0);

    // backpressure in DONE, then operand noise while BUSY
    run_op(4'd9, 2'd2, 4'd4, 2'd1, 1'b0, 5, 4, 1'b0);
    run_op(4'd7, 2'd0, 4'd15, 2'd0, 1'b1, 5, 1, 1'b0);
    run_op(4'd13, 2'd3, 4'd4, 2'd1, 1'b0, 2, 4, 1'b1);

    // reset in BUSY with two iterations left
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 4'd14;
    divisor  = 2'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre-reset state busy", int'(dbg_state), 1);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", int'(in_ready), 1);
    check("abort out_valid", int'(out_valid), 0);
    check("abort state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort no result", int'(out_valid), 0);
    end
    run_op(4'd12, 2'd3, 4'd4, 2'd0, 1'b0, 0, 4, 1'b0);

    for (int a = 0; a < 4; a++)
      for (int b = 1; b < 4; b++)
        run_op(4'(a * b), 2'(b), 4'(a), 2'd0, 1'b0, 0, 4, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 4; b++)
        run_model(a, b, $urandom_range(0, 2));

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
